motor_executor: RTL
===================

# motor_executor

Motor-side responder to the robot navigation controller's command outputs. It decodes the controller's level commands (`stop_motor`, `front_motor`, `turn_left`, `turn_right`, `rotate`) into PWM-gated enable and direction signals for the left and right drive motors. It times each finite maneuver and returns the `done` level that the controller's next-state logic consumes. It sits between the controller and the motor driver pins.

## Interface
- `TURN_CYCLES`, 1000, drive cycles for one turn_left/turn_right maneuver (≥1)
- `ROTATE_CYCLES`, 2000, drive cycles for one rotate maneuver (≥1)
- `PWM_PERIOD`, 16, PWM period in clk cycles (≥1)
- `PWM_DUTY`, 12, PWM high cycles per period (0..PWM_PERIOD; equal to PWM_PERIOD means always on)
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `stop_motor` in 1: stop command (level)
- `front_motor` in 1: drive forward (level)
- `turn_left` in 1: timed left turn (level)
- `turn_right` in 1: timed right turn (level)
- `rotate` in 1: timed in-place rotate (level)
- `left_en` out 1: left motor enable, PWM-gated
- `left_dir` out 1: left direction, 1 = forward, 0 = reverse
- `right_en` out 1: right motor enable, PWM-gated
- `right_dir` out 1: right direction, 1 = forward
- `done` out 1: maneuver complete; level, held while the completed command stays asserted

## Operation
- States: IDLE, FWD, TURN_L, TURN_R, ROT, STOP, DONE.
- Command priority when more than one is high: stop_motor > rotate > turn_left > turn_right > front_motor. The winning command is the "active command".
- Drive per state:
  - FWD: left forward, right forward.
  - TURN_L: left off, right forward.
  - TURN_R: left forward, right off.
  - ROT: left reverse, right forward.
  - STOP, DONE, IDLE: both enables 0. Both dirs 1 (default forward).
- `*_en = drive_on && pwm_on`. Here `pwm_on = (pwm_cnt < PWM_DUTY)`. `pwm_cnt` free-runs 0..PWM_PERIOD-1, wraps to 0, and is reset to 0 only by `reset`.
- Maneuver counter, width `$clog2(max(TURN_CYCLES,ROTATE_CYCLES)+1)`:
  - Cleared on every state entry.
  - Increments each cycle in TURN_L, TURN_R and ROT.
  - When it equals LIMIT-1, the next state is DONE.
- DONE:
  - `done` = 1 and motors are off.
  - Stays in DONE while the same command remains the active command.
- STOP: `done` rises the cycle after entry and is held while `stop_motor` stays high. No count is involved.
- FWD is continuous. `done` stays 0.
- Active command changes (including mid-maneuver or in DONE): abort the current state and enter the new command's state on the next edge, counter = 0, `done` = 0.
- No command high: IDLE on the next edge.
- A maneuver is not restarted while its command stays high. A new maneuver requires the command to drop or another command to take priority.

## Timing
- All outputs are registered.
- Reset values: all enables 0, dirs 1, `done` 0, state IDLE, counters 0. Reset mid-maneuver has the same effect and the maneuver is discarded.
- Latency from command to drive:
  - A command sampled high at edge k sets the state at edge k.
  - Enable/dir reflect it at edge k+1, gated by PWM.
- Maneuver length:
  - drive_on is high for exactly LIMIT cycles.
  - DONE is entered at edge k+LIMIT and `done` is visible after edge k+LIMIT+1.
- Command drop: `done` clears and motors stop one edge after the command is sampled low.
- `PWM_DUTY` = 0 gives enables that are always 0, but maneuver timing is unchanged (the counter runs on drive_on, not on PWM).

## Structure
- `motor_pkg`: state enum, DIR_FWD/DIR_REV constants, priority-encoded command enum.
- Sub-module `pwm_gen`:
  - Parameters PERIOD and DUTY.
  - Ports clk, reset, `pwm_on`.
  - Instantiated once and shared by both motors.
- Top: priority encoder, FSM, maneuver counter, output registers.

## Test plan
- Reset check: with any inputs, assert reset for 2 cycles → all en 0, dirs 1, done 0. Repeat reset mid-ROT at count 500 → IDLE, done stays 0.
- TURN_CYCLES=8, PWM_DUTY=PWM_PERIOD, turn_left held → right_en 1 for exactly 8 cycles, left_en 0, then done=1 held until turn_left drops; done=0 one cycle after the drop.
- ROTATE_CYCLES=4, rotate held → left_dir=0, left_en=right_en=1 for 4 cycles, then done=1.
- PWM_PERIOD=4, PWM_DUTY=1, front_motor held 12 cycles → each en high 1 of every 4 cycles (3 pulses), done stays 0.
- Priority and abort:
  - rotate and turn_right together → ROT is taken.
  - turn_left switched to stop_motor at count 3 → motors off next edge, done=1 one cycle later.
- Invalid retrigger: turn_right held through DONE for 20 cycles → no second maneuver, done stays 1.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types for the motor executor: FSM states, direction levels, prioritised commands.
// Latency: n/a (types and a pure helper only).
// Backpressure: none.
package motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_TURN_L,
    ST_TURN_R,
    ST_ROT,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Listed from highest to lowest priority after CMD_NONE.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_ROT,
    CMD_TURN_L,
    CMD_TURN_R,
    CMD_FWD
  } cmd_t;

  function automatic state_t cmd_state(input cmd_t c);
    state_t s;
    case (c)
      CMD_STOP:   s = ST_STOP;
      CMD_ROT:    s = ST_ROT;
      CMD_TURN_L: s = ST_TURN_L;
      CMD_TURN_R: s = ST_TURN_R;
      CMD_FWD:    s = ST_FWD;
      default:    s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/motor_executor_pwm_gen.sv
// Free-running PWM reference shared by both motors; high for DUTY of every PERIOD cycles.
// Latency: pwm_on is combinational from the phase counter, which starts at 0 after reset.
// Backpressure: none; runs every cycle.
module pwm_gen #(
  parameter int PERIOD = 16,
  parameter int DUTY   = 12
) (
  input  logic clk,
  input  logic reset,
  output logic pwm_on
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0]  LAST   = W'(PERIOD - 1);
  localparam logic [31:0]   DUTY_U = 32'(DUTY);

  logic [W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Compared at 32 bits so DUTY == PERIOD yields an always-on output.
  assign pwm_on = ({{(32 - W){1'b0}}, pwm_cnt} < DUTY_U);

endmodule

// File: rtl/motor_executor.sv
// Decodes prioritised level commands into PWM-gated motor enables/dirs and times maneuvers.
// Latency: command sampled at edge k sets state at k, drive pins and done follow at k+1.
// Backpressure: none; commands are levels, done is held while the finished command stays active.
module motor_executor
  import motor_pkg::*;
#(
  parameter int TURN_CYCLES   = 1000,
  parameter int ROTATE_CYCLES = 2000,
  parameter int PWM_PERIOD    = 16,
  parameter int PWM_DUTY      = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic stop_motor,
  input  logic front_motor,
  input  logic turn_left,
  input  logic turn_right,
  input  logic rotate,
  output logic left_en,
  output logic left_dir,
  output logic right_en,
  output logic right_dir,
  output logic done
);

  localparam int MAX_CYC = (TURN_CYCLES > ROTATE_CYCLES) ? TURN_CYCLES : ROTATE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROT_LAST  = CNT_W'(ROTATE_CYCLES - 1);

  state_t           state;
  cmd_t             cur_cmd;
  cmd_t             act_cmd;
  logic [CNT_W-1:0] man_cnt;
  logic             pwm_on;

  logic l_on, l_dir, r_on, r_dir, done_nxt;

  pwm_gen #(
    .PERIOD(PWM_PERIOD),
    .DUTY  (PWM_DUTY)
  ) u_pwm (
    .clk   (clk),
    .reset (reset),
    .pwm_on(pwm_on)
  );

  always_comb begin
    act_cmd = CMD_NONE;
    if (stop_motor)       act_cmd = CMD_STOP;
    else if (rotate)      act_cmd = CMD_ROT;
    else if (turn_left)   act_cmd = CMD_TURN_L;
    else if (turn_right)  act_cmd = CMD_TURN_R;
    else if (front_motor) act_cmd = CMD_FWD;
  end

  always_comb begin
    l_on     = 1'b0;
    r_on     = 1'b0;
    l_dir    = DIR_FWD;
    r_dir    = DIR_FWD;
    done_nxt = 1'b0;
    case (state)
      ST_FWD: begin
        l_on = 1'b1;
        r_on = 1'b1;
      end
      ST_TURN_L: r_on = 1'b1;
      ST_TURN_R: l_on = 1'b1;
      ST_ROT: begin
        l_on  = 1'b1;
        r_on  = 1'b1;
        l_dir = DIR_REV;
      end
      ST_STOP, ST_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_cmd   <= CMD_NONE;
      man_cnt   <= '0;
      left_en   <= 1'b0;
      right_en  <= 1'b0;
      left_dir  <= DIR_FWD;
      right_dir <= DIR_FWD;
      done      <= 1'b0;
    end else begin
      left_en   <= l_on && pwm_on;
      right_en  <= r_on && pwm_on;
      left_dir  <= l_dir;
      right_dir <= r_dir;
      done      <= done_nxt;

      // A change of winning command aborts whatever is running, DONE included;
      // an unchanged command never restarts its maneuver.
      if (act_cmd != cur_cmd) begin
        cur_cmd <= act_cmd;
        state   <= cmd_state(act_cmd);
        man_cnt <= '0;
      end else begin
        case (state)
          ST_TURN_L, ST_TURN_R: begin
            if (man_cnt == TURN_LAST) begin
              state   <= ST_DONE;
              man_cnt <= '0;
            end else begin
              man_cnt <= man_cnt + 1'b1;
            end
          end
          ST_ROT: begin
            if (man_cnt == ROT_LAST) begin
              state   <= ST_DONE;
              man_cnt <= '0;
            end else begin
              man_cnt <= man_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
